// File: rtl/ddr3_wr_gen_if.sv
// MC user command / write-data channel bundle between the write generator and the controller.
// master: traffic generator side. slave: memory-controller side.
interface ddr3_wr_gen_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
);
    logic [2:0]          cmd;
    logic                cmd_en;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_data_en;
    logic                wr_data_end;
    logic [DATA_W/8-1:0] wr_data_mask;
    logic                wr_data_rdy;

    modport master (
        output cmd, cmd_en, addr, wr_data, wr_data_en, wr_data_end, wr_data_mask,
        input  cmd_ready, wr_data_rdy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, wr_data_en, wr_data_end, wr_data_mask,
        output cmd_ready, wr_data_rdy
    );
endinterface

// File: rtl/ddr3_wr_gen.sv
// DDR3 1:4 self-test write generator: after calibration, writes NUM_BURSTS index-derived bursts
// starting at BASE_ADDR, with independent command and data channels, then raises wr_done.
// Optional feature macro: ERR_INJECT_EN (corrupts bit 0 of beat INJ_IDX when inj_en is high).
module ddr3_wr_gen #(
    parameter int unsigned       ADDR_W     = 28,
    parameter int unsigned       DATA_W     = 128,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       NUM_BURSTS = 1024,
    parameter logic [31:0]       SEED       = 32'hA5A5_5A5A,
    parameter logic [15:0]       INJ_IDX    = 16'd100
) (
    input  logic                 clk_x1,
    input  logic                 rst,
    input  logic                 init_calib_complete,
    input  logic                 start,
    input  logic                 inj_en,
    ddr3_wr_gen_if.master        mc,
    output logic                 busy,
    output logic                 wr_done,
    output logic [15:0]          burst_cnt
);

    localparam int unsigned Lanes = DATA_W / 32;
    localparam logic [15:0] NumB  = 16'(NUM_BURSTS);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWaitCal = 2'd1;
    localparam logic [1:0] StWrite   = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [15:0]       ci_q, ci_d;
    logic [15:0]       di_q, di_d;
    logic              cmd_en_q, cmd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_done_q, wr_done_d;

    logic              cmd_acc, dat_acc;
    logic [15:0]       ci_inc, di_inc;

    // Burst k: word {k, ~k} ^ SEED replicated across 32-bit lanes, lane j XORed with j.
    function automatic logic [DATA_W-1:0] pattern(input logic [15:0] k);
        logic [31:0]       w;
        logic [DATA_W-1:0] d;
        w = {k, ~k} ^ SEED;
        d = '0;
        for (int j = 0; j < Lanes; j++) begin
            d[j*32 +: 32] = w ^ 32'(j);
        end
        return d;
    endfunction

    assign cmd_acc = cmd_en_q & mc.cmd_ready;
    assign dat_acc = wr_en_q & mc.wr_data_rdy;
    assign ci_inc  = ci_q + 16'(cmd_acc);
    assign di_inc  = di_q + 16'(dat_acc);

    // Next-state: FSM, channel indices and the registered valid/payload of each channel.
    always_comb begin
        state_d   = state_q;
        ci_d      = ci_q;
        di_d      = di_q;
        cmd_en_d  = cmd_en_q;
        addr_d    = addr_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        wr_done_d = wr_done_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWaitCal;
                    ci_d    = '0;
                    di_d    = '0;
                end
            end
            StWaitCal: begin
                if (init_calib_complete) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                ci_d = ci_inc;
                di_d = di_inc;
                if (ci_inc == NumB && di_inc == NumB) begin
                    state_d   = StDone;
                    wr_done_d = 1'b1;
                    cmd_en_d  = 1'b0;
                    wr_en_d   = 1'b0;
                end else begin
                    // Command may run at most two bursts ahead of data.
                    if (cmd_en_q && !mc.cmd_ready) begin
                        cmd_en_d = 1'b1;
                    end else if (init_calib_complete && ci_inc < NumB &&
                                 {1'b0, ci_inc} < {1'b0, di_inc} + 17'd2) begin
                        cmd_en_d = 1'b1;
                        addr_d   = BASE_ADDR + (ADDR_W'(ci_inc) << 3);
                    end else begin
                        cmd_en_d = 1'b0;
                    end
                    // Data may run at most one burst ahead of commands.
                    if (wr_en_q && !mc.wr_data_rdy) begin
                        wr_en_d = 1'b1;
                    end else if (init_calib_complete && di_inc < NumB && di_inc <= ci_inc) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = pattern(di_inc);
`ifdef ERR_INJECT_EN
                        if (inj_en && di_inc == INJ_IDX) begin
                            wr_data_d[0] = ~wr_data_d[0];
                        end
`endif
                    end else begin
                        wr_en_d = 1'b0;
                    end
                end
            end
            StDone: begin
                if (start) begin
                    state_d   = StWaitCal;
                    wr_done_d = 1'b0;
                    ci_d      = '0;
                    di_d      = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ERR_INJECT_EN
`else
    logic unused_inj;
    assign unused_inj = inj_en ^ (^INJ_IDX);
`endif

    // State registers; reset aborts any pass in progress immediately.
    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ci_q      <= '0;
            di_q      <= '0;
            cmd_en_q  <= 1'b0;
            addr_q    <= BASE_ADDR;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ci_q      <= ci_d;
            di_q      <= di_d;
            cmd_en_q  <= cmd_en_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign mc.cmd          = 3'b000;
    assign mc.cmd_en       = cmd_en_q;
    assign mc.addr         = addr_q;
    assign mc.wr_data      = wr_data_q;
    assign mc.wr_data_en   = wr_en_q;
    assign mc.wr_data_end  = wr_en_q;
    assign mc.wr_data_mask = '0;

    assign busy      = (state_q == StWaitCal) || (state_q == StWrite);
    assign wr_done   = wr_done_q;
    assign burst_cnt = di_q;

endmodule

// File: tb/tb_ddr3_wr_gen.sv
// Bench for ddr3_wr_gen: a transaction-count reference model (accepted commands/beats) for a
// randomized 48-burst instance, plus a cycle table for a 4-burst instance that wraps the address.
module tb_ddr3_wr_gen;

    localparam int unsigned AW     = 28;
    localparam int unsigned DW     = 128;
    localparam logic [27:0] A_BASE = 28'h0000100;
    localparam int          A_NUM  = 48;
    localparam logic [15:0] A_INJ  = 16'd2;
    localparam logic [27:0] B_BASE = 28'hFFFFFF0;
    localparam logic [31:0] SEED   = 32'hA5A5_5A5A;
`ifdef ERR_INJECT_EN
    localparam bit InjBuilt = 1'b1;
`else
    localparam bit InjBuilt = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        calib_a, start_a, inj_a, busy_a, done_a;
    logic [15:0] bcnt_a;
    logic        calib_b, start_b, inj_b, busy_b, done_b;
    logic [15:0] bcnt_b;

    ddr3_wr_gen_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
    ddr3_wr_gen_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

    ddr3_wr_gen #(
        .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(A_BASE), .NUM_BURSTS(A_NUM),
        .SEED(SEED), .INJ_IDX(A_INJ)
    ) dut_a (
        .clk_x1(clk), .rst(rst), .init_calib_complete(calib_a), .start(start_a),
        .inj_en(inj_a), .mc(if_a.master), .busy(busy_a), .wr_done(done_a), .burst_cnt(bcnt_a)
    );

    ddr3_wr_gen #(
        .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(B_BASE), .NUM_BURSTS(4),
        .SEED(SEED), .INJ_IDX(16'd100)
    ) dut_b (
        .clk_x1(clk), .rst(rst), .init_calib_complete(calib_b), .start(start_b),
        .inj_en(inj_b), .mc(if_b.master), .busy(busy_b), .wr_done(done_b), .burst_cnt(bcnt_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state for dut_a.
    int n_cmd = 0, n_beat = 0;
    bit m_busy = 0, m_done = 0;
    bit hold_c = 0, hold_d = 0, prev_c = 0, prev_d = 0, prev_calib = 0;
    bit quiet = 0, first_chk = 0;

    // Cycle table state for dut_b.
    bit b_active = 0;
    int b_cyc = 0;
    logic [27:0] b_addrs [4] = '{28'hFFFFFF0, 28'hFFFFFF8, 28'h0000000, 28'h0000008};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int k, input bit inj);
        logic [15:0]  kk;
        logic [31:0]  w;
        logic [127:0] d;
        kk = 16'(k);
        w  = {kk, ~kk} ^ SEED;
        for (int j = 0; j < 4; j++) d[j*32 +: 32] = w ^ 32'(j);
        if (inj && kk == A_INJ) d[0] = ~d[0];
        return d;
    endfunction

    task automatic chk_reset_a();
        chk("rst_cmd_en", if_a.cmd_en, 1'b0);
        chk("rst_data_en", if_a.wr_data_en, 1'b0);
        chk("rst_data_end", if_a.wr_data_end, 1'b0);
        chk("rst_addr", if_a.addr, A_BASE);
        chk("rst_data", if_a.wr_data, 128'h0);
        chk("rst_cmd", if_a.cmd, 3'b000);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_burst_cnt", bcnt_a, 16'h0);
    endtask

    task automatic model_reset();
        n_cmd = 0; n_beat = 0; m_busy = 0; m_done = 0;
        hold_c = 0; hold_d = 0; prev_c = 0; prev_d = 0;
    endtask

    task automatic monitor_a();
        bit start_acc;
        chk("a_busy", busy_a, m_busy);
        chk("a_done", done_a, m_done);
        chk("a_burst_cnt", bcnt_a, 16'(n_beat));
        chk("a_cmd_code", if_a.cmd, 3'b000);
        chk("a_mask", if_a.wr_data_mask, 16'h0);
        if (if_a.wr_data_en) chk("a_data_end", if_a.wr_data_end, 1'b1);
        else                 chk("a_data_end", if_a.wr_data_end, 1'b0);
        if (hold_c) chk("a_cmd_hold", if_a.cmd_en, 1'b1);
        if (hold_d) chk("a_data_hold", if_a.wr_data_en, 1'b1);
        if (quiet) chk("a_no_cmd", if_a.cmd_en, 1'b0);
        if (first_chk) chk("a_first_cmd", if_a.cmd_en, 1'b1);
        if (if_a.cmd_en && !prev_c) chk("a_cmd_cal_gate", prev_calib, 1'b1);
        if (if_a.wr_data_en && !prev_d) chk("a_data_cal_gate", prev_calib, 1'b1);
        if (if_a.cmd_en) begin
            chk("a_addr", if_a.addr, 28'(int'(A_BASE) + n_cmd * 8));
            chk("a_cmd_window", (n_cmd < n_beat + 2) && (n_cmd < A_NUM), 1'b1);
        end
        if (if_a.wr_data_en) begin
            chk("a_data", if_a.wr_data, pat(n_beat, inj_a && InjBuilt));
            chk("a_data_window", (n_beat <= n_cmd) && (n_beat < A_NUM), 1'b1);
        end
        start_acc  = start_a && !m_busy;
        hold_c     = if_a.cmd_en && !if_a.cmd_ready;
        hold_d     = if_a.wr_data_en && !if_a.wr_data_rdy;
        prev_c     = if_a.cmd_en;
        prev_d     = if_a.wr_data_en;
        prev_calib = calib_a;
        if (if_a.cmd_en && if_a.cmd_ready) n_cmd++;
        if (if_a.wr_data_en && if_a.wr_data_rdy) n_beat++;
        if (m_busy && n_cmd == A_NUM && n_beat == A_NUM) begin
            m_busy = 0;
            m_done = 1;
        end
        if (start_acc) begin
            m_busy = 1; m_done = 0; n_cmd = 0; n_beat = 0;
        end
    endtask

    task automatic monitor_b();
        bit en;
        if (!b_active) return;
        en = (b_cyc >= 3) && (b_cyc <= 6);
        chk("b_cmd_en", if_b.cmd_en, en);
        chk("b_data_en", if_b.wr_data_en, en);
        chk("b_busy", busy_b, (b_cyc >= 1) && (b_cyc <= 6));
        chk("b_done", done_b, b_cyc >= 7);
        if (en) begin
            chk("b_addr", if_b.addr, b_addrs[b_cyc-3]);
            chk("b_data", if_b.wr_data, pat(b_cyc - 3, 1'b0));
        end
        b_cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor_a();
        monitor_b();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy_a(input int pc, input int pd);
        if_a.cmd_ready   = ($urandom_range(99) < pc);
        if_a.wr_data_rdy = ($urandom_range(99) < pd);
    endtask

    initial begin
        rst = 1'b1;
        calib_a = 1'b0; start_a = 1'b0; inj_a = 1'b1;
        calib_b = 1'b1; start_b = 1'b0; inj_b = 1'b0;
        if_a.cmd_ready = 1'b0; if_a.wr_data_rdy = 1'b0;
        if_b.cmd_ready = 1'b1; if_b.wr_data_rdy = 1'b1;

        // Reset state.
        @(negedge clk);
        chk_reset_a();
        chk("b_rst_addr", if_b.addr, B_BASE);
        chk("b_rst_cmd_en", if_b.cmd_en, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        cycle();

        // 4-burst pass on dut_b, ready always high: back-to-back issue and address wrap.
        b_cyc = 0;
        b_active = 1;
        start_b = 1'b1;
        cycle();
        start_b = 1'b0;
        repeat (9) cycle();
        b_active = 0;

        // Start before calibration: held in WAIT_CAL with no commands.
        quiet = 1;
        start_a = 1'b1;
        set_rdy_a(50, 50);
        cycle();
        start_a = 1'b0;
        for (int i = 0; i < 50; i++) begin
            set_rdy_a(50, 50);
            cycle();
        end
        calib_a = 1'b1;
        cycle();
        cycle();
        quiet = 0;

        // Data channel stalled, command ready random: command lead stays bounded.
        for (int i = 0; i < 10; i++) begin
            if_a.cmd_ready   = $urandom_range(1);
            if_a.wr_data_rdy = 1'b0;
            first_chk = (i == 0);
            cycle();
        end
        first_chk = 0;

        // Random back-pressure and calibration drops until the pass completes.
        for (int i = 0; i < 3000 && !m_done; i++) begin
            set_rdy_a(70, 70);
            calib_a = ($urandom_range(15) != 0);
            cycle();
        end
        calib_a = 1'b1;
        chk("a_pass1_complete", m_done, 1'b1);
        repeat (3) begin
            set_rdy_a(50, 50);
            cycle();
        end

        // Second pass from DONE, reset asynchronously at beat 37.
        inj_a = 1'b0;
        start_a = 1'b1;
        set_rdy_a(80, 80);
        cycle();
        start_a = 1'b0;
        for (int i = 0; i < 1000 && n_beat < 37; i++) begin
            set_rdy_a(80, 80);
            cycle();
        end
        chk("a_mid_beat", bcnt_a, 16'd37);
        rst = 1'b1;
        #1;
        chk_reset_a();
        model_reset();
        cycle();
        rst = 1'b0;
        cycle();

        // Fresh pass after reset must restart at burst 0.
        start_a = 1'b1;
        set_rdy_a(90, 90);
        cycle();
        start_a = 1'b0;
        for (int i = 0; i < 2000 && !m_done; i++) begin
            set_rdy_a(90, 90);
            cycle();
        end
        chk("a_pass2_complete", m_done, 1'b1);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
